lane_ctrl_trainer: RTL and testbench
====================================

Name: lane_ctrl_trainer

Overview:
- Fabric-side initiator that drives the control inputs of one DDR4 PHY lane controller and consumes its status outputs.
- Per lane, it runs read-gate (READ_CLK_SEL) training, then an RX DQS delay-line eye sweep, and finally centres the delay line in the passing window.
- Read bursts are requested from the external read/compare engine through a REQ/ACK handshake.
- One instance per lane, above the lane controller wrapper.

Parameters:
- MAX_TAPS, 128: number of delay taps swept per lane.
- TAP_W, 7: width of tap counters and window outputs; clog2(MAX_TAPS).
- SETTLE_CYC, 8: FAB_CLK cycles of wait after each MOVE pulse, and the length of the HS_IO_CLK_PAUSE window.
- ACK_TIMEOUT, 1023: maximum cycles RD_REQ may wait for RD_ACK.

Ports:
- FAB_CLK  in  1  fabric clock; the only clock.
- ARST_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle pulse; begins training; ignored while BUSY.
- RD_REQ  out  1  request one read burst plus compare from the read engine.
- RD_ACK  in  1  one-cycle completion of the requested read.
- RD_PASS  in  1  compare result, valid only when RD_ACK=1.
- RX_BURST_DETECT  in  1  burst detect from the lane controller.
- RX_DELAY_LINE_OUT_OF_RANGE  in  1  delay line at its end stop.
- READ_CLK_SEL  out  3  read-gate clock select.
- HS_IO_CLK_PAUSE  out  1  pauses the high-speed clock while READ_CLK_SEL changes.
- DELAY_LINE_SEL  out  1  1 = RX DQS delay line addressed.
- DELAY_LINE_LOAD  out  1  one-cycle pulse; reloads the default delay.
- DELAY_LINE_DIRECTION  out  1  1 = increment, 0 = decrement.
- DELAY_LINE_MOVE  out  1  one-cycle pulse; one tap step.
- BUSY  out  1  training in progress.
- DONE  out  1  sticky success flag.
- ERR  out  1  sticky failure flag.
- ERR_CODE  out  2  0 none, 1 no gate found, 2 no passing window, 3 RD_ACK timeout.
- WIN_START  out  TAP_W  first passing tap.
- WIN_END  out  TAP_W  last passing tap.

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE, applied asynchronously on ARST_N low, including mid-operation. Release is synchronous to FAB_CLK.
- States: IDLE, LOAD, GATE_SET, GATE_RD, DLY_RD, DLY_MOVE, DLY_SETTLE, CENTER, FINISH, FAIL.
- IDLE: on START, clear DONE/ERR/ERR_CODE/WIN_*. Set BUSY=1 and DELAY_LINE_SEL=1. Go to LOAD.
- LOAD: DELAY_LINE_LOAD=1 for exactly 1 cycle; tap counter = 0; sel = 0. Go to GATE_SET.
- GATE_SET:
  - READ_CLK_SEL takes the value of sel in the first cycle of the pause.
  - HS_IO_CLK_PAUSE=1 for SETTLE_CYC cycles, then 0.
  - Go to GATE_RD.
- Read handshake (GATE_RD and DLY_RD):
  - RD_REQ rises on state entry and stays high through the RD_ACK cycle.
  - RD_REQ is 0 the cycle after RD_ACK.
  - If RD_ACK is absent for ACK_TIMEOUT cycles: FAIL with code 3, RD_REQ dropped.
- GATE_RD burst detection:
  - RX_BURST_DETECT is OR-accumulated from RD_REQ rise up to and including the RD_ACK cycle.
  - Detected: go to DLY_RD.
  - Not detected and sel<7: sel++, go to GATE_SET.
  - Not detected and sel==7: FAIL with code 1; READ_CLK_SEL stays 7.
- DLY_RD, evaluated on RD_ACK:
  - Pass with no window yet: WIN_START = WIN_END = tap; in_win=1.
  - Pass inside the window: WIN_END = tap.
  - Fail with in_win=1: window closed; go to CENTER.
  - Otherwise, if tap==MAX_TAPS-1 or RX_DELAY_LINE_OUT_OF_RANGE=1 is sampled on the ACK cycle: go to CENTER if in_win, else FAIL with code 2.
  - Otherwise go to DLY_MOVE.
- DLY_MOVE: DIRECTION=1, MOVE=1 for 1 cycle, tap++. Go to DLY_SETTLE.
- DLY_SETTLE: wait SETTLE_CYC cycles, then go to DLY_RD.
- CENTER:
  - target = (WIN_START+WIN_END)>>1, computed at TAP_W+1 bits, so there is no overflow.
  - Issue (tap - target) MOVE pulses with DIRECTION=0, each followed by SETTLE_CYC cycles; tap-- per pulse.
  - Zero pulses if tap==target.
  - DIRECTION is held stable 1 cycle before and during each MOVE.
- FINISH: DONE=1, BUSY=0, DELAY_LINE_SEL=0; return to IDLE.
- FAIL: ERR=1, ERR_CODE set, BUSY=0, DELAY_LINE_SEL=0; return to IDLE.
- READ_CLK_SEL and the delay-line position are retained after FINISH or FAIL.
- MOVE and LOAD are never high in the same cycle. RD_REQ is never high during MOVE or during PAUSE.
- START during BUSY has no effect. START in the same cycle as ARST_N deassertion is ignored.

Decomposition:
- Package lane_trn_pkg holds:
  - state enum
  - ERR_CODE constants (ERR_NONE, ERR_NO_GATE, ERR_NO_WIN, ERR_TIMEOUT)
  - default parameter constants
- Sub-module lane_trn_wait_cnt: a loadable down-counter with a zero flag, shared for the settle, pause and ACK-timeout waits.

Test Plan:
- Burst first seen at sel=3; pass at taps 10..20, fail at 21 -> READ_CLK_SEL=3; WIN_START=10, WIN_END=20; 21 forward MOVEs then 6 DIRECTION=0 MOVEs (final tap 15); DONE=1, ERR=0.
- RX_BURST_DETECT never asserted -> 8 GATE_RD handshakes; ERR=1, ERR_CODE=1, READ_CLK_SEL=7, zero MOVE pulses.
- Pass from tap 30, OUT_OF_RANGE at tap 40 with pass -> WIN 30..40, 5 back MOVEs (final tap 35), DONE=1.
- RD_ACK withheld during the first gate read -> ERR_CODE=3 after 1023 cycles, RD_REQ=0 the next cycle, BUSY=0.
- ARST_N pulled low mid-sweep (tap 12) -> all outputs 0 immediately; a later START reissues LOAD and re-sweeps from sel 0.
- Pass only at tap 0, fail at 1; extra START pulses while BUSY -> WIN 0..0, 1 back MOVE, exactly one training run, DONE=1.

Source files
------------

// File: rtl/lane_trn_pkg.sv
// rtl/lane_trn_pkg.sv - shared constants for the lane read-gate / delay-line trainer
package lane_trn_pkg;

   // Default build parameters for one DDR4 lane
   localparam int MAX_TAPS_DEF    = 128;
   localparam int TAP_W_DEF       = 7;
   localparam int SETTLE_CYC_DEF  = 8;
   localparam int ACK_TIMEOUT_DEF = 1023;

   // Failure codes reported on err_code
   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_NO_GATE = 2'd1;
   localparam logic [1:0] ERR_NO_WIN  = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   // Training FSM state encoding
   localparam logic [3:0] ST_IDLE       = 4'd0;
   localparam logic [3:0] ST_LOAD       = 4'd1;
   localparam logic [3:0] ST_GATE_SET   = 4'd2;
   localparam logic [3:0] ST_GATE_RD    = 4'd3;
   localparam logic [3:0] ST_DLY_RD     = 4'd4;
   localparam logic [3:0] ST_DLY_MOVE   = 4'd5;
   localparam logic [3:0] ST_DLY_SETTLE = 4'd6;
   localparam logic [3:0] ST_CENTER     = 4'd7;
   localparam logic [3:0] ST_FINISH     = 4'd8;
   localparam logic [3:0] ST_FAIL       = 4'd9;

endpackage

// File: rtl/lane_trn_wait_cnt.sv
// rtl/lane_trn_wait_cnt.sv - loadable down-counter with zero flag for settle, pause and ack timeout
module lane_trn_wait_cnt
   import lane_trn_pkg::*;
#(
   parameter int W = $clog2(ACK_TIMEOUT_DEF + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ld,
   input  logic [W-1:0] ld_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   // Load wins over counting; the count parks at zero until reloaded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (ld) begin
         cnt <= ld_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/lane_ctrl_trainer.sv
// rtl/lane_ctrl_trainer.sv - per-lane read-gate training, RX DQS eye sweep and delay-line centring
module lane_ctrl_trainer
   import lane_trn_pkg::*;
#(
   parameter int MAX_TAPS    = MAX_TAPS_DEF,
   parameter int TAP_W       = TAP_W_DEF,
   parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
   input  logic             fab_clk,
   input  logic             arst_n,
   input  logic             start,
   output logic             rd_req,
   input  logic             rd_ack,
   input  logic             rd_pass,
   input  logic             rx_burst_detect,
   input  logic             rx_delay_line_out_of_range,
   output logic [2:0]       read_clk_sel,
   output logic             hs_io_clk_pause,
   output logic             delay_line_sel,
   output logic             delay_line_load,
   output logic             delay_line_direction,
   output logic             delay_line_move,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [1:0]       err_code,
   output logic [TAP_W-1:0] win_start,
   output logic [TAP_W-1:0] win_end
);

   localparam int               CNT_W     = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] PAUSE_LD  = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);
   localparam logic [CNT_W-1:0] ACK_LD    = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [TAP_W-1:0] TAP_LAST  = TAP_W'(MAX_TAPS - 1);
   localparam logic [TAP_W-1:0] TAP_ONE   = TAP_W'(1);

   logic [3:0]       state;
   logic [2:0]       sel;
   logic [TAP_W-1:0] tap;
   logic             in_win;
   logic             det_acc;
   logic             ctr_ph;
   logic             armed;
   logic [1:0]       fail_code;

   logic             cnt_ld;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_zero;
   logic             det;
   logic [TAP_W:0]   win_sum;
   logic [TAP_W:0]   center_tap;
   logic             at_target;

   // Burst detect seen anywhere in the current request, including the ack cycle
   assign det        = det_acc | rx_burst_detect;
   // Midpoint at one extra bit so the sum of two high taps cannot wrap
   assign win_sum    = {1'b0, win_start} + {1'b0, win_end};
   assign center_tap = win_sum >> 1;
   assign at_target  = ({1'b0, tap} == center_tap);

   // Counter reload points: pause on gate change, ack timeout on request, settle after each move
   always_comb begin
      cnt_ld  = 1'b0;
      cnt_val = '0;
      case (state)
         ST_LOAD: begin
            cnt_ld  = 1'b1;
            cnt_val = PAUSE_LD;
         end
         ST_GATE_RD: begin
            if (!rd_req) begin
               cnt_ld  = 1'b1;
               cnt_val = ACK_LD;
            end else if (rd_ack && !det && sel != 3'd7) begin
               cnt_ld  = 1'b1;
               cnt_val = PAUSE_LD;
            end
         end
         ST_DLY_RD: begin
            if (!rd_req) begin
               cnt_ld  = 1'b1;
               cnt_val = ACK_LD;
            end
         end
         ST_DLY_MOVE: begin
            cnt_ld  = 1'b1;
            cnt_val = SETTLE_LD;
         end
         ST_CENTER: begin
            if (!ctr_ph && !at_target) begin
               cnt_ld  = 1'b1;
               cnt_val = SETTLE_LD;
            end
         end
         default: ;
      endcase
   end

   lane_trn_wait_cnt #(
      .W (CNT_W)
   ) u_wait_cnt (
      .clk    (fab_clk),
      .rst_n  (arst_n),
      .ld     (cnt_ld),
      .ld_val (cnt_val),
      .zero   (cnt_zero)
   );

   // Training sequencer; all lane-controller outputs are registered here
   always_ff @(posedge fab_clk or negedge arst_n) begin
      if (!arst_n) begin
         state                <= ST_IDLE;
         sel                  <= '0;
         tap                  <= '0;
         in_win               <= 1'b0;
         det_acc              <= 1'b0;
         ctr_ph               <= 1'b0;
         armed                <= 1'b0;
         fail_code            <= ERR_NONE;
         rd_req               <= 1'b0;
         read_clk_sel         <= '0;
         hs_io_clk_pause      <= 1'b0;
         delay_line_sel       <= 1'b0;
         delay_line_load      <= 1'b0;
         delay_line_direction <= 1'b0;
         delay_line_move      <= 1'b0;
         busy                 <= 1'b0;
         done                 <= 1'b0;
         err                  <= 1'b0;
         err_code             <= ERR_NONE;
         win_start            <= '0;
         win_end              <= '0;
      end else begin
         // armed stays low for the first edge after reset release so a coincident start is dropped
         armed           <= 1'b1;
         delay_line_load <= 1'b0;
         delay_line_move <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && armed) begin
                  done            <= 1'b0;
                  err             <= 1'b0;
                  err_code        <= ERR_NONE;
                  win_start       <= '0;
                  win_end         <= '0;
                  busy            <= 1'b1;
                  delay_line_sel  <= 1'b1;
                  delay_line_load <= 1'b1;
                  state           <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               tap             <= '0;
               sel             <= '0;
               in_win          <= 1'b0;
               ctr_ph          <= 1'b0;
               read_clk_sel    <= '0;
               hs_io_clk_pause <= 1'b1;
               state           <= ST_GATE_SET;
            end
            ST_GATE_SET: begin
               if (cnt_zero) begin
                  hs_io_clk_pause <= 1'b0;
                  state           <= ST_GATE_RD;
               end
            end
            ST_GATE_RD: begin
               if (!rd_req) begin
                  rd_req  <= 1'b1;
                  det_acc <= 1'b0;
               end else if (rd_ack) begin
                  rd_req <= 1'b0;
                  if (det) begin
                     state <= ST_DLY_RD;
                  end else if (sel != 3'd7) begin
                     sel             <= sel + 3'd1;
                     read_clk_sel    <= sel + 3'd1;
                     hs_io_clk_pause <= 1'b1;
                     state           <= ST_GATE_SET;
                  end else begin
                     fail_code <= ERR_NO_GATE;
                     state     <= ST_FAIL;
                  end
               end else if (cnt_zero) begin
                  rd_req    <= 1'b0;
                  fail_code <= ERR_TIMEOUT;
                  state     <= ST_FAIL;
               end else begin
                  det_acc <= det;
               end
            end
            ST_DLY_RD: begin
               if (!rd_req) begin
                  rd_req <= 1'b1;
               end else if (rd_ack) begin
                  rd_req <= 1'b0;
                  if (rd_pass) begin
                     if (!in_win) begin
                        win_start <= tap;
                     end
                     win_end <= tap;
                     in_win  <= 1'b1;
                  end
                  if (!rd_pass && in_win) begin
                     delay_line_direction <= 1'b0;
                     ctr_ph               <= 1'b0;
                     state                <= ST_CENTER;
                  end else if (tap == TAP_LAST || rx_delay_line_out_of_range) begin
                     if (in_win || rd_pass) begin
                        delay_line_direction <= 1'b0;
                        ctr_ph               <= 1'b0;
                        state                <= ST_CENTER;
                     end else begin
                        fail_code <= ERR_NO_WIN;
                        state     <= ST_FAIL;
                     end
                  end else begin
                     delay_line_direction <= 1'b1;
                     state                <= ST_DLY_MOVE;
                  end
               end else if (cnt_zero) begin
                  rd_req    <= 1'b0;
                  fail_code <= ERR_TIMEOUT;
                  state     <= ST_FAIL;
               end
            end
            ST_DLY_MOVE: begin
               delay_line_move <= 1'b1;
               tap             <= tap + TAP_ONE;
               state           <= ST_DLY_SETTLE;
            end
            ST_DLY_SETTLE: begin
               if (cnt_zero) begin
                  state <= ST_DLY_RD;
               end
            end
            ST_CENTER: begin
               // ctr_ph=0 decides/issues a step, ctr_ph=1 waits out the settle time
               if (!ctr_ph) begin
                  if (at_target) begin
                     state <= ST_FINISH;
                  end else begin
                     delay_line_move <= 1'b1;
                     tap             <= tap - TAP_ONE;
                     ctr_ph          <= 1'b1;
                  end
               end else if (cnt_zero) begin
                  ctr_ph <= 1'b0;
               end
            end
            ST_FINISH: begin
               done           <= 1'b1;
               busy           <= 1'b0;
               delay_line_sel <= 1'b0;
               state          <= ST_IDLE;
            end
            ST_FAIL: begin
               err            <= 1'b1;
               err_code       <= fail_code;
               busy           <= 1'b0;
               delay_line_sel <= 1'b0;
               state          <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lane_ctrl_trainer.sv
// tb/tb_lane_ctrl_trainer.sv - self-checking bench for lane_ctrl_trainer
module tb_lane_ctrl_trainer;

   logic       fab_clk = 1'b0;
   logic       arst_n = 1'b0;
   logic       start = 1'b0;
   logic       rd_ack = 1'b0;
   logic       rd_pass = 1'b0;
   logic       rx_burst_detect = 1'b0;
   logic       rx_dlo = 1'b0;
   logic       rd_req;
   logic [2:0] read_clk_sel;
   logic       hs_io_clk_pause;
   logic       delay_line_sel;
   logic       delay_line_load;
   logic       delay_line_direction;
   logic       delay_line_move;
   logic       busy;
   logic       done;
   logic       err;
   logic [1:0] err_code;
   logic [6:0] win_start;
   logic [6:0] win_end;
   logic [27:0] outs;

   int checks = 0;
   int errors = 0;

   // Lane controller / read engine model state
   int tap_pos = 0;
   int fwd_cnt = 0;
   int back_cnt = 0;
   int load_cnt = 0;
   int hs_cnt = 0;
   int viol_cnt = 0;
   int first_sel = -1;
   int gate_sel = 0;
   int pass_lo = 0;
   int pass_hi = -1;
   int oor_tap = 255;
   bit withhold = 1'b0;

   lane_ctrl_trainer dut (
      .fab_clk                    (fab_clk),
      .arst_n                     (arst_n),
      .start                      (start),
      .rd_req                     (rd_req),
      .rd_ack                     (rd_ack),
      .rd_pass                    (rd_pass),
      .rx_burst_detect            (rx_burst_detect),
      .rx_delay_line_out_of_range (rx_dlo),
      .read_clk_sel               (read_clk_sel),
      .hs_io_clk_pause            (hs_io_clk_pause),
      .delay_line_sel             (delay_line_sel),
      .delay_line_load            (delay_line_load),
      .delay_line_direction       (delay_line_direction),
      .delay_line_move            (delay_line_move),
      .busy                       (busy),
      .done                       (done),
      .err                        (err),
      .err_code                   (err_code),
      .win_start                  (win_start),
      .win_end                    (win_end)
   );

   assign outs = {rd_req, read_clk_sel, hs_io_clk_pause, delay_line_sel, delay_line_load,
                  delay_line_direction, delay_line_move, busy, done, err, err_code,
                  win_start, win_end};

   always #5 fab_clk = ~fab_clk;

   // Responder: tracks delay-line position, answers reads, flags protocol violations
   initial begin
      int  req_age;
      int  lat;
      int  bd_at;
      bit  ack_prev;
      bit  dir_prev;
      req_age = 0; lat = 0; bd_at = 0; dir_prev = 1'b0;
      forever begin
         @(negedge fab_clk);
         ack_prev = rd_ack;
         if (arst_n) begin
            if (delay_line_move && delay_line_direction !== dir_prev) viol_cnt++;
            if (delay_line_move) begin
               if (delay_line_direction) begin tap_pos++; fwd_cnt++; end
               else begin tap_pos--; back_cnt++; end
            end
            if (delay_line_load) begin tap_pos = 0; load_cnt++; end
            if (delay_line_move && delay_line_load) viol_cnt++;
            if (rd_req && (delay_line_move || hs_io_clk_pause)) viol_cnt++;
            if (ack_prev && rd_req) viol_cnt++;
         end
         dir_prev = delay_line_direction;
         rd_ack = 1'b0;
         rd_pass = 1'($urandom_range(0, 1));
         rx_dlo = (tap_pos == oor_tap);
         if (arst_n && rd_req && !ack_prev) begin
            if (req_age == 0) begin
               lat = $urandom_range(0, 5);
               bd_at = $urandom_range(0, lat);
            end
            rx_burst_detect = (read_clk_sel == gate_sel) && (req_age == bd_at);
            if (!withhold && req_age == lat) begin
               rd_ack = 1'b1;
               rd_pass = (tap_pos >= pass_lo) && (tap_pos <= pass_hi);
               hs_cnt++;
               if (first_sel < 0) first_sel = read_clk_sel;
            end
            req_age++;
         end else begin
            req_age = 0;
            rx_burst_detect = 1'($urandom_range(0, 1));
         end
      end
   end

   task automatic clear_counts();
      fwd_cnt = 0; back_cnt = 0; load_cnt = 0; hs_cnt = 0; viol_cnt = 0; first_sel = -1;
   endtask

   task automatic pulse_start();
      @(negedge fab_clk);
      start = 1'b1;
      @(negedge fab_clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int limit, output bit ok);
      int n;
      n = 0;
      while (busy && n < limit) begin
         @(negedge fab_clk);
         n++;
      end
      ok = !busy;
   endtask

   // One training run checked against results derived from the window/end-stop arithmetic
   task automatic run_case(input string name, input int g, input int lo, input int hi, input int oor);
      int end_tap, e_code, e_sel, e_ws, e_we, e_fwd, e_back, e_tap, e_hs;
      bit ok;
      end_tap = (oor < 127) ? oor : 127;
      e_ws = 0; e_we = 0; e_back = 0;
      if (g > 7) begin
         e_code = 1; e_sel = 7; e_fwd = 0; e_tap = 0; e_hs = 8;
      end else begin
         e_sel = g;
         if (lo > hi || lo > end_tap) begin
            e_code = 2; e_fwd = end_tap; e_tap = end_tap;
         end else begin
            e_code = 0; e_ws = lo;
            if (hi < end_tap) begin e_we = hi; e_fwd = hi + 1; end
            else begin e_we = end_tap; e_fwd = end_tap; end
            e_tap = (e_ws + e_we) / 2;
            e_back = e_fwd - e_tap;
         end
         e_hs = g + 1 + e_fwd + 1;
      end
      gate_sel = g; pass_lo = lo; pass_hi = hi; oor_tap = oor;
      clear_counts();
      pulse_start();
      wait_idle(10000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL %s idle: busy still %0d", name, busy); end
      checks++; if (done !== 1'(e_code == 0)) begin errors++; $display("FAIL %s done: got %0d want %0d", name, done, e_code == 0); end
      checks++; if (err !== 1'(e_code != 0)) begin errors++; $display("FAIL %s err: got %0d want %0d", name, err, e_code != 0); end
      checks++; if (err_code !== 2'(e_code)) begin errors++; $display("FAIL %s err_code: got %0d want %0d", name, err_code, e_code); end
      checks++; if (read_clk_sel !== 3'(e_sel)) begin errors++; $display("FAIL %s read_clk_sel: got %0d want %0d", name, read_clk_sel, e_sel); end
      checks++; if (win_start !== 7'(e_ws)) begin errors++; $display("FAIL %s win_start: got %0d want %0d", name, win_start, e_ws); end
      checks++; if (win_end !== 7'(e_we)) begin errors++; $display("FAIL %s win_end: got %0d want %0d", name, win_end, e_we); end
      checks++; if (fwd_cnt != e_fwd) begin errors++; $display("FAIL %s fwd_moves: got %0d want %0d", name, fwd_cnt, e_fwd); end
      checks++; if (back_cnt != e_back) begin errors++; $display("FAIL %s back_moves: got %0d want %0d", name, back_cnt, e_back); end
      checks++; if (tap_pos != e_tap) begin errors++; $display("FAIL %s final_tap: got %0d want %0d", name, tap_pos, e_tap); end
      checks++; if (hs_cnt != e_hs) begin errors++; $display("FAIL %s handshakes: got %0d want %0d", name, hs_cnt, e_hs); end
      checks++; if (load_cnt != 1) begin errors++; $display("FAIL %s loads: got %0d want 1", name, load_cnt); end
      checks++; if (first_sel != 0) begin errors++; $display("FAIL %s first_gate_sel: got %0d want 0", name, first_sel); end
      checks++; if (viol_cnt != 0) begin errors++; $display("FAIL %s protocol_violations: got %0d want 0", name, viol_cnt); end
      checks++; if (delay_line_sel !== 1'b0) begin errors++; $display("FAIL %s delay_line_sel: got %0d want 0", name, delay_line_sel); end
   endtask

   task automatic test_reset();
      arst_n = 1'b0;
      start = 1'b1;
      repeat (3) @(negedge fab_clk);
      start = 1'b0;
      checks++; if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", outs); end
   endtask

   task automatic test_start_at_release();
      @(negedge fab_clk);
      arst_n = 1'b1;
      start = 1'b1;
      @(negedge fab_clk);
      start = 1'b0;
      repeat (3) @(negedge fab_clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_at_release busy: got %0d want 0", busy); end
      checks++; if (load_cnt != 0) begin errors++; $display("FAIL start_at_release loads: got %0d want 0", load_cnt); end
   endtask

   task automatic test_directed();
      run_case("gate3_win10_20", 3, 10, 20, 255);
      run_case("no_gate", 8, 0, 10, 255);
      run_case("oor_at_40", 0, 30, 60, 40);
      run_case("no_window", 5, 300, 300, 20);
   endtask

   task automatic test_timeout();
      int n;
      bit ok;
      withhold = 1'b1;
      gate_sel = 0; pass_lo = 0; pass_hi = 5; oor_tap = 255;
      clear_counts();
      pulse_start();
      n = 0;
      while (!rd_req && n < 200) begin @(negedge fab_clk); n++; end
      n = 0;
      while (rd_req && n < 3000) begin @(negedge fab_clk); n++; end
      checks++; if (n != 1023) begin errors++; $display("FAIL timeout_req_cycles: got %0d want 1023", n); end
      @(negedge fab_clk);
      checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL timeout_rd_req_after: got %0d want 0", rd_req); end
      wait_idle(5, ok);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %0d want 0", busy); end
      checks++; if (err !== 1'b1 || err_code !== 2'd3) begin errors++; $display("FAIL timeout_err: got err=%0d code=%0d want 1/3", err, err_code); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL timeout_done: got %0d want 0", done); end
      withhold = 1'b0;
   endtask

   task automatic test_reset_mid_sweep();
      int n;
      gate_sel = 2; pass_lo = 50; pass_hi = 60; oor_tap = 255;
      clear_counts();
      pulse_start();
      n = 0;
      while (tap_pos != 12 && n < 5000) begin @(negedge fab_clk); n++; end
      checks++; if (tap_pos != 12) begin errors++; $display("FAIL mid_reset_reach_tap12: got %0d want 12", tap_pos); end
      #2 arst_n = 1'b0;
      #1;
      checks++; if (outs !== '0) begin errors++; $display("FAIL mid_reset_outputs: got %h want 0", outs); end
      repeat (2) @(negedge fab_clk);
      arst_n = 1'b1;
      repeat (2) @(negedge fab_clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_idle: got busy %0d want 0", busy); end
      run_case("after_reset", 2, 5, 8, 255);
   endtask

   task automatic test_start_while_busy();
      int extra;
      bit ok;
      gate_sel = 1; pass_lo = 0; pass_hi = 0; oor_tap = 255;
      clear_counts();
      pulse_start();
      extra = 0;
      for (int k = 0; k < 3; k++) begin
         repeat (3) @(negedge fab_clk);
         if (busy) extra++;
         pulse_start();
      end
      wait_idle(5000, ok);
      checks++; if (extra != 3) begin errors++; $display("FAIL busy_start_landed: got %0d want 3", extra); end
      checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL busy_done: got done=%0d err=%0d want 1/0", done, err); end
      checks++; if (win_start !== 7'd0 || win_end !== 7'd0) begin errors++; $display("FAIL busy_win: got %0d..%0d want 0..0", win_start, win_end); end
      checks++; if (fwd_cnt != 1 || back_cnt != 1) begin errors++; $display("FAIL busy_moves: got fwd=%0d back=%0d want 1/1", fwd_cnt, back_cnt); end
      repeat (20) @(negedge fab_clk);
      checks++; if (busy !== 1'b0 || load_cnt != 1) begin errors++; $display("FAIL busy_single_run: got busy=%0d loads=%0d want 0/1", busy, load_cnt); end
   endtask

   task automatic test_random();
      int g, lo, hi, oor;
      for (int i = 0; i < 8; i++) begin
         g = $urandom_range(0, 8);
         lo = $urandom_range(0, 90);
         hi = lo + $urandom_range(0, 25);
         if ($urandom_range(0, 4) == 0) begin lo = 300; hi = 300; end
         oor = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 110) : 255;
         run_case($sformatf("rand%0d", i), g, lo, hi, oor);
      end
   endtask

   initial begin
      test_reset();
      test_start_at_release();
      test_directed();
      test_timeout();
      test_reset_mid_sweep();
      test_start_while_busy();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
